// File: rtl/run_ctrl_pkg.sv
// Shared session state encoding and default geometry for the host run controller.
package run_ctrl_pkg;

  localparam int DW_DEF        = 8;
  localparam int AW_DEF        = 8;
  localparam int START_CYC_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    START,
    RUN,
    DUMP,
    DONE
  } state_t;

endpackage

// File: rtl/dump_streamer.sv
// Walks the result window of data memory: issues one read, aligns the 1-cycle read
// latency, and holds each word on the rd_* register until the consumer takes it.
module dump_streamer
  import run_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic          rd_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          active,
  output logic [AW-1:0] mem_addr,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic          pend;
  logic [AW-1:0] addr;
  logic [AW:0]   remain;

  assign mem_addr = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      pend     <= 1'b0;
      addr     <= '0;
      remain   <= '0;
      rd_valid <= 1'b0;
      rd_addr  <= '0;
      rd_data  <= '0;
    end else if (start) begin
      active   <= (len != '0);
      pend     <= 1'b0;
      addr     <= base;
      remain   <= len;
      rd_valid <= 1'b0;
    end else if (active) begin
      if (pend) begin
        // mem_rdata now reflects the address issued last cycle
        pend     <= 1'b0;
        rd_valid <= 1'b1;
        rd_data  <= mem_rdata;
        rd_addr  <= addr;
        addr     <= addr + 1'b1;
        remain   <= remain - 1'b1;
      end else if (rd_valid) begin
        if (rd_ready) begin
          rd_valid <= 1'b0;
          if (remain == '0) active <= 1'b0;
        end
      end else begin
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/host_run_ctrl.sv
// Host-side session sequencer: clear, preload, start, run, dump. Optional RUN-state
// watchdog is built when RUN_TIMEOUT_EN is defined (adds TIMEOUT and timed_out).
module host_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int START_CYC = START_CYC_DEF
`ifdef RUN_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 2**20
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic [AW-1:0] dump_base,
  input  logic [AW:0]   dump_len,
  output logic          mem_own,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_start,
  input  logic          cpu_halt,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [31:0]   run_cycles
`ifdef RUN_TIMEOUT_EN
  , output logic        timed_out
`endif
);

  localparam logic [AW-1:0] START_LAST = AW'(START_CYC - 1);

  state_t        state, state_nx;
  logic [AW-1:0] cnt;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          accept, strm_start, strm_active;
  logic [AW-1:0] strm_addr;
  logic [31:0]   run_inc;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign accept  = ld_valid && ld_ready;
  assign run_inc = sat_inc(run_cycles);

  always_comb begin
    state_nx   = state;
    strm_start = 1'b0;
    case (state)
      IDLE, DONE: if (go) state_nx = CLEAR;
      CLEAR:      if (&cnt) state_nx = LOAD;
      LOAD:       if (accept && ld_last) state_nx = START;
      START:      if (cnt == START_LAST) state_nx = RUN;
      RUN: begin
        if (cpu_halt) begin
          if (len_q == '0) begin
            state_nx = DONE;
          end else begin
            state_nx   = DUMP;
            strm_start = 1'b1;
          end
        end
`ifdef RUN_TIMEOUT_EN
        else if (run_inc == 32'(TIMEOUT)) state_nx = DONE;
`endif
      end
      DUMP:       if (!strm_active) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      base_q      <= '0;
      len_q       <= '0;
      run_cycles  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef RUN_TIMEOUT_EN
      timed_out   <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      cnt      <= (state_nx != state) ? '0 : cnt + 1'b1;
      mem_we_q <= 1'b0;
      if ((state == IDLE || state == DONE) && go) begin
        base_q     <= dump_base;
        len_q      <= dump_len;
        run_cycles <= '0;
`ifdef RUN_TIMEOUT_EN
        timed_out  <= 1'b0;
`endif
      end
      if (state == CLEAR) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= cnt;
        mem_wdata_q <= '0;
      end
      if (accept) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= ld_addr;
        mem_wdata_q <= ld_data;
      end
      if (state == RUN) run_cycles <= run_inc;
`ifdef RUN_TIMEOUT_EN
      if (state == RUN && !cpu_halt && run_inc == 32'(TIMEOUT)) timed_out <= 1'b1;
`endif
    end
  end

  dump_streamer #(.DW(DW), .AW(AW)) u_streamer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (strm_start),
    .base      (base_q),
    .len       (len_q),
    .rd_ready  (rd_ready),
    .mem_rdata (mem_rdata),
    .active    (strm_active),
    .mem_addr  (strm_addr),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  // The final preload write lands in the first START cycle, so ownership is released only once it has
  assign mem_own   = !((state == START || state == RUN) && !mem_we_q);
  assign mem_we    = mem_we_q;
  assign mem_addr  = (state == DUMP) ? strm_addr : mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_start = (state != RUN);
  assign ld_ready  = (state == LOAD);
  assign busy      = !(state == IDLE || state == DONE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_host_run_ctrl.sv
// Randomized session bench for host_run_ctrl with a data memory, a toy CPU and a
// scoreboard of expected dump words (with RUN_TIMEOUT_EN also exercises the watchdog).
module tb_host_run_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, go, ld_valid, ld_ready, ld_last;
  logic [7:0] ld_addr, ld_data, dump_base;
  logic [8:0] dump_len;
  logic       mem_own, mem_we, cpu_start, cpu_halt, rd_valid, rd_ready, busy, done;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, rd_addr, rd_data;
  logic [31:0] run_cycles;
  logic       cpu_we;
  logic [7:0] cpu_waddr, cpu_wdata;
`ifdef RUN_TIMEOUT_EN
  logic       timed_out;
`endif

  int total = 0;
  int bad   = 0;
  int bp_mode = 0;
  int wait_cnt = 0;

  logic [7:0]  tb_mem [256];
  logic [7:0]  bq_a[$];
  logic [7:0]  bq_d[$];
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  host_run_ctrl #(
    .DW(8), .AW(8), .START_CYC(2)
`ifdef RUN_TIMEOUT_EN
    , .TIMEOUT(100)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .dump_base(dump_base), .dump_len(dump_len),
    .mem_own(mem_own), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_start(cpu_start), .cpu_halt(cpu_halt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .run_cycles(run_cycles)
`ifdef RUN_TIMEOUT_EN
    , .timed_out(timed_out)
`endif
  );

  // Data memory behind the mem_own mux; synchronous read.
  always @(posedge clk) begin
    if (mem_own) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    end else if (cpu_we) begin
      tb_mem[cpu_waddr] <= cpu_wdata;
    end
    mem_rdata <= tb_mem[mem_own ? mem_addr : cpu_waddr];
  end

  // Consumer backpressure: 0 always ready, 1 random, 2 five idle cycles per word.
  always begin
    @(posedge clk);
    #2;
    if (bp_mode == 0) rd_ready = 1'b1;
    else if (bp_mode == 1) rd_ready = 1'($urandom_range(0, 1));
    else if (rd_valid) begin
      if (wait_cnt >= 5) begin rd_ready = 1'b1; wait_cnt = 0; end
      else begin rd_ready = 1'b0; wait_cnt++; end
    end else begin
      rd_ready = 1'b0; wait_cnt = 0;
    end
  end

  // Scoreboard monitor.
  logic       hold_q = 1'b0;
  logic [7:0] hold_a, hold_d;
  logic [15:0] e;
  always @(negedge clk) begin
    if (!rst_n) hold_q = 1'b0;
    else begin
      if (hold_q) begin
        total++;
        if (!rd_valid || rd_addr !== hold_a || rd_data !== hold_d) begin
          bad++;
          $display("FAIL hold_stable got v=%0b a=%h d=%h want a=%h d=%h", rd_valid, rd_addr, rd_data, hold_a, hold_d);
        end
      end
      hold_q = 1'b0;
      if (rd_valid && rd_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word got a=%h d=%h want none", rd_addr, rd_data);
        end else begin
          e = exp_q.pop_front();
          if ({rd_addr, rd_data} !== e) begin
            bad++;
            $display("FAIL dump_word got a=%h d=%h want a=%h d=%h", rd_addr, rd_data, e[15:8], e[7:0]);
          end
        end
      end else if (rd_valid) begin
        hold_q = 1'b1; hold_a = rd_addr; hold_d = rd_data;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_cpu_start"}, cpu_start, 1);
    chk({tag, "_mem_own"}, mem_own, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_ld_ready"}, ld_ready, 0);
  endtask

  // One session. halt_after=0 means the CPU never halts (watchdog build only).
  task automatic session(input logic [7:0] base, input logic [8:0] len, input int halt_after,
                         input int bp, input bit use_cpu, input bit halt_in_start,
                         input bit go_in_run, input bit rst_in_load);
    logic [7:0] mdl [256];
    int w, rc;
    bp_mode = bp;
    cpu_waddr = (len != 0) ? 8'(base + ($urandom % len)) : 8'($urandom);
    cpu_wdata = 8'($urandom);
    @(negedge clk);
    dump_base = base; dump_len = len; go = 1'b1;
    @(negedge clk);
    go = 1'b0; dump_base = 8'($urandom); dump_len = 9'($urandom);
    chk("go_busy", busy, 1);
    chk("go_done", done, 0);
    chk("go_run_cycles", run_cycles, 0);
`ifdef RUN_TIMEOUT_EN
    chk("go_timed_out", timed_out, 0);
`endif
    w = 0;
    while (ld_ready !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    chk("ld_ready_wait", ld_ready, 1);
    for (int i = 0; i < bq_a.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin ld_valid = 1'b0; @(negedge clk); end
      ld_valid = 1'b1; ld_addr = bq_a[i]; ld_data = bq_d[i]; ld_last = (i == bq_a.size() - 1);
      @(negedge clk);
      if (rst_in_load && i == 1) begin
        rst_n = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        #1 reset_checks("mid_load_rst");
        @(negedge clk); rst_n = 1'b1;
        bq_a.delete(); bq_d.delete();
        return;
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    foreach (mdl[k]) mdl[k] = 8'h00;
    foreach (bq_a[k]) mdl[bq_a[k]] = bq_d[k];
    if (use_cpu) mdl[cpu_waddr] = cpu_wdata;
    if (halt_after != 0)
      for (int i = 0; i < len; i++) exp_q.push_back({8'(base + i), mdl[8'(base + i)]});
    bq_a.delete(); bq_d.delete();
    chk("start_cpu_start", cpu_start, 1);
    if (halt_in_start) begin
      cpu_halt = 1'b1;
      @(negedge clk);
      cpu_halt = 1'b0;
    end
    w = 0;
    while (cpu_start !== 1'b0 && w < 20) begin @(negedge clk); w++; end
    chk("run_entered", cpu_start, 0);
    chk("run_mem_own", mem_own, 0);
    rc = 1;
    cpu_we = use_cpu;
    if (halt_after == 0) begin
`ifdef RUN_TIMEOUT_EN
      w = 0;
      while (done !== 1'b1 && w < 200) begin @(negedge clk); cpu_we = 1'b0; w++; end
      chk("to_done", done, 1);
      chk("to_timed_out", timed_out, 1);
      chk("to_run_cycles", run_cycles, 100);
      chk("to_cpu_start", cpu_start, 1);
`endif
      cpu_we = 1'b0;
      return;
    end
    cpu_halt = (halt_after == 1);
    while (rc < halt_after) begin
      @(negedge clk);
      cpu_we = 1'b0; go = 1'b0; rc++;
      if (go_in_run && rc == 2) begin go = 1'b1; dump_base = ~base; dump_len = 9'd5; end
      if (rc == halt_after) cpu_halt = 1'b1;
    end
    @(negedge clk);
    cpu_halt = 1'b0; cpu_we = 1'b0; go = 1'b0;
    chk("post_halt_cpu_start", cpu_start, 1);
    chk("post_halt_mem_own", mem_own, 1);
    w = 0;
    while (done !== 1'b1 && w < 6000) begin @(negedge clk); w++; end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("run_cycles", run_cycles, halt_after);
    chk("words_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [8:0] l;
    int n;
    foreach (tb_mem[k]) tb_mem[k] = 8'($urandom);
    rst_n = 1'b0; go = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
    dump_base = '0; dump_len = '0; cpu_halt = 1'b0; cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    // Directed preload and dump of a 4-word window.
    bq_a = '{8'd8, 8'd9, 8'd10, 8'd11}; bq_d = '{8'h00, 8'h01, 8'h00, 8'h00};
    session(8'd8, 9'd4, 40, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Heavy backpressure.
    bq_a = '{8'h40, 8'h41, 8'h43, 8'h45}; bq_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    session(8'h40, 9'd6, 17, 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Address wrap.
    bq_a = '{8'hFE, 8'hFF, 8'h00, 8'h01}; bq_d = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    session(8'hFE, 9'd4, 5, 1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Empty window, halt on the very first RUN cycle.
    bq_a = '{8'h10}; bq_d = '{8'h55};
    session(8'h10, 9'd0, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Duplicate addresses, halt during START, go during RUN.
    bq_a = '{8'h20, 8'h21, 8'h20, 8'h22}; bq_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    session(8'h20, 9'd3, 10, 1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset during LOAD, then a normal session.
    bq_a = '{8'h30, 8'h31, 8'h32, 8'h33}; bq_d = '{8'h01, 8'h02, 8'h03, 8'h04};
    session(8'h30, 9'd4, 8, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    bq_a = '{8'h30, 8'h33}; bq_d = '{8'h77, 8'h88};
    session(8'h30, 9'd4, 8, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 5; s++) begin
      b = 8'($urandom);
      l = 9'($urandom_range(0, 40));
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        bq_a.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(b + $urandom_range(0, 40)));
        bq_d.push_back(8'($urandom));
      end
      session(b, l, $urandom_range(1, 60), $urandom_range(0, 2), 1'b1, 1'b0, 1'b0, 1'b0);
    end

`ifdef RUN_TIMEOUT_EN
    bq_a = '{8'h50}; bq_d = '{8'h66};
    session(8'h50, 9'd4, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("to_words_left", exp_q.size(), 0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
